// File: rtl/perf_pkg.sv
// Shared constants and types for the performance counter bank.
//   MODE_WRAP / MODE_SAT : values for the SAT_MODE parameter
//   SEL_W / sel_t        : width and type of the shadow read select
package perf_pkg;

    localparam int MODE_WRAP = 0;
    localparam int MODE_SAT  = 1;
    localparam int SEL_W     = 4;

    typedef logic [SEL_W-1:0] sel_t;

endpackage

// File: rtl/perf_counter_bank_if.sv
// Control and readback bundle for perf_counter_bank.
//   inc     : per-channel event pulses
//   freeze  : blocks counting (clr and snap still act)
//   clr     : synchronous clear of live counters and overflow flags
//   snap    : copy live counters into shadow registers
//   rd_sel  : shadow channel select
//   rd_data : registered shadow value of the selected channel
//   ovf     : sticky per-channel overflow flags
//   irq     : OR of all ovf bits
interface perf_counter_bank_if
    import perf_pkg::*;
#(
    parameter int NUM_CH = 4,
    parameter int CNT_W  = 11
);
    logic [NUM_CH-1:0] inc;
    logic              freeze;
    logic              clr;
    logic              snap;
    sel_t              rd_sel;
    logic [CNT_W-1:0]  rd_data;
    logic [NUM_CH-1:0] ovf;
    logic              irq;

    modport master (
        output inc, freeze, clr, snap, rd_sel,
        input  rd_data, ovf, irq
    );

    modport slave (
        input  inc, freeze, clr, snap, rd_sel,
        output rd_data, ovf, irq
    );
endinterface

// File: rtl/perf_counter_cell.sv
// One channel of the counter bank: live counter, shadow copy and sticky
// overflow flag.
//   clk, reset : clock and asynchronous active-low reset
//   inc_en     : count one event this edge (freeze already folded in)
//   clr        : clear live counter and ovf (shadow untouched)
//   snap       : load shadow from the pre-edge live value
//   shadow     : captured count
//   ovf        : sticky overflow flag
module perf_counter_cell
    import perf_pkg::*;
#(
    parameter int CNT_W    = 11,
    parameter int SAT_MODE = MODE_WRAP
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             inc_en,
    input  logic             clr,
    input  logic             snap,
    output logic [CNT_W-1:0] shadow,
    output logic             ovf
);

    localparam logic [CNT_W-1:0] ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    logic [CNT_W-1:0] live;
    logic             at_max;

    assign at_max = (live == {CNT_W{1'b1}});

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            live   <= '0;
            shadow <= '0;
            ovf    <= 1'b0;
        end else begin
            // Shadow takes the value from before this edge's clear/increment.
            if (snap) begin
                shadow <= live;
            end
            if (clr) begin
                live <= '0;
                ovf  <= 1'b0;
            end else if (inc_en) begin
                if (at_max) begin
                    ovf  <= 1'b1;
                    live <= (SAT_MODE == MODE_SAT) ? live : '0;
                end else begin
                    live <= live + ONE;
                end
            end
        end
    end

endmodule

// File: rtl/perf_counter_bank.sv
// Bank of NUM_CH event counters with snapshot shadows, sticky overflow
// flags, an overflow interrupt and a registered shadow read port.
//   clk   : sole clock, rising edge
//   reset : asynchronous active-low reset
//   bus   : perf_counter_bank_if slave (inc, freeze, clr, snap, rd_sel in;
//           rd_data, ovf, irq out)
module perf_counter_bank
    import perf_pkg::*;
#(
    parameter int NUM_CH   = 4,
    parameter int CNT_W    = 11,
    parameter int SAT_MODE = MODE_WRAP
) (
    input logic                 clk,
    input logic                 reset,
    perf_counter_bank_if.slave  bus
);

    logic [CNT_W-1:0]  shadow [NUM_CH];
    logic [NUM_CH-1:0] ovf_r;
    logic [CNT_W-1:0]  rd_mux;

    for (genvar k = 0; k < NUM_CH; k++) begin : g_ch
        perf_counter_cell #(
            .CNT_W    (CNT_W),
            .SAT_MODE (SAT_MODE)
        ) u_cell (
            .clk    (clk),
            .reset  (reset),
            .inc_en (bus.inc[k] & ~bus.freeze),
            .clr    (bus.clr),
            .snap   (bus.snap),
            .shadow (shadow[k]),
            .ovf    (ovf_r[k])
        );
    end

    // Selects with no matching channel fall through to zero.
    always_comb begin
        rd_mux = '0;
        for (int k = 0; k < NUM_CH; k++) begin
            if (bus.rd_sel == SEL_W'(k)) begin
                rd_mux = shadow[k];
            end
        end
    end

    // Registered from the pre-edge shadow, so a read on the snap edge
    // returns the old captured value.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            bus.rd_data <= '0;
        end else begin
            bus.rd_data <= rd_mux;
        end
    end

    assign bus.ovf = ovf_r;
    assign bus.irq = |ovf_r;

endmodule

// File: doc/perf_counter_bank.md
PERF_COUNTER_BANK -- requirements
Module: perf_counter_bank

Interface
REQ-001 SHALL have parameter NUM_CH, default 4, number of event counter channels (1..16).
REQ-002 SHALL have parameter CNT_W, default 11, counter width in bits (4..32).
REQ-003 SHALL have parameter SAT_MODE, default 0; 0 = wrap on overflow, 1 = saturate at all-ones.
REQ-004 SHALL have port clk, input, 1, sole clock; all state updates on rising edge.
REQ-005 SHALL have port reset, input, 1, asynchronous active-low reset.
REQ-006 SHALL have port inc, input, NUM_CH, per-channel event pulse; bit k high for one cycle = one event on channel k.
REQ-007 SHALL have port freeze, input, 1; high blocks counting only.
REQ-008 SHALL have port clr, input, 1, synchronous clear of all counters and overflow flags.
REQ-009 SHALL have port snap, input, 1; copies all live counters into shadow registers.
REQ-010 SHALL have port rd_sel, input, 4, shadow channel select.
REQ-011 SHALL have port rd_data, output, CNT_W, registered shadow value of selected channel.
REQ-012 SHALL have port ovf, output, NUM_CH, sticky per-channel overflow flags.
REQ-013 SHALL have port irq, output, 1, OR of all ovf bits.

Function
REQ-014 SHALL increment live counter k by exactly 1 on each rising edge where inc[k]=1, freeze=0 and clr=0.
REQ-015 SHALL, with SAT_MODE=0 and counter k at all-ones, wrap it to 0 on increment and set ovf[k].
REQ-016 SHALL, with SAT_MODE=1 and counter k at all-ones, hold it at all-ones on increment and set ovf[k].
REQ-017 SHALL keep ovf[k] set until clr or reset; further overflows leave it set.
REQ-018 SHALL, on clr=1, set all live counters and ovf to 0 at the next edge, regardless of inc and freeze (clr beats inc).
REQ-019 SHALL leave shadow registers unchanged on clr.
REQ-020 SHALL, on snap=1, load every shadow register with its live counter value before that edge's increment or clear.
REQ-021 SHALL leave clr and snap unaffected by freeze.
REQ-022 SHALL update rd_data at the edge after rd_sel is sampled (1-cycle latency), from shadow[rd_sel].
REQ-023 SHALL, for the same edge, present the pre-snap shadow value on rd_data (snap and read in one cycle return the old shadow).
REQ-024 SHALL drive rd_data to 0 when rd_sel >= NUM_CH.
REQ-025 SHALL derive irq combinationally from the ovf register; it carries no extra latency.

Reset
REQ-026 SHALL, while reset=0, immediately force all live counters, shadow registers, ovf and rd_data to 0; irq therefore 0.
REQ-027 SHALL abandon any in-progress increment, snap or read when reset asserts mid-operation; the first edge after release counts normally.

Structure
REQ-028 SHALL take the mode constants MODE_WRAP=0 and MODE_SAT=1 and the rd_sel width from shared package perf_pkg.
REQ-029 SHALL be built from NUM_CH instances of sub-module perf_counter_cell (live counter, shadow, ovf for one channel) plus a read mux register.
REQ-030 SHALL size at 120-400 lines of RTL in total.

Verification
REQ-031 SHALL check wrap: CNT_W=4, SAT_MODE=0, 17 pulses on inc[0], snap, rd_sel=0 -> rd_data=1, ovf[0]=1, irq=1.
REQ-032 SHALL check saturate: CNT_W=4, SAT_MODE=1, 20 pulses on inc[1], snap, rd_sel=1 -> rd_data=15, ovf[1]=1.
REQ-033 SHALL check clr priority: counter 2 = 5, inc[2]=1 and clr=1 same edge -> live count 0, ovf=0, shadow unchanged.
REQ-034 SHALL check snap ordering: counter 3 = 9, snap=1 and inc[3]=1 same edge -> shadow[3]=9, live=10; rd_sel=3 gives rd_data=9 one cycle later.
REQ-035 SHALL check freeze: freeze=1 for 10 cycles with inc=4'b1111 -> all counters unchanged; snap during freeze still captures.
REQ-036 SHALL check reset mid-count: reset low asynchronously between edges after 6 events -> all outputs 0 immediately; rd_sel=7 with NUM_CH=4 -> rd_data=0.
